sar_search_controller: RTL and testbench
========================================

Name: sar_search_controller

Overview:
- Successive-approximation search engine that sits on the B side of a magnitude comparator.
- Drives a registered probe value into the comparator and reads back its greater-than and equal flags. Binary-searches MSB-first to recover the comparator's hidden A operand.
- Serves as the consuming end of the comparator interface: the comparator reports A vs B; this block generates B and decides from the reports.
- Used for threshold and value discovery wherever only compare results are observable.

Parameters:
- WIDTH, 4, operand width in bits (A, probe, result); legal range 1..16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a search; sampled only in IDLE
- probe  out  WIDTH  registered trial value driven to comparator B input
- cmp_gt  in  1  comparator flag, A > probe (combinational from probe)
- cmp_eq  in  1  comparator flag, A == probe (combinational from probe)
- busy  out  1  high from the cycle after start acceptance through the DONE cycle
- done  out  1  single-cycle pulse, result valid
- result  out  WIDTH  recovered A; held until next accepted start
- found  out  1  exact equality seen during search; held with result
- err  out  1  cmp_gt and cmp_eq both high in an EVAL cycle; sticky until next accepted start

Behaviour:
- One clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0. Internal state: state=IDLE, acc=0, idx=WIDTH-1.
- States:
  - IDLE: start=1 moves to SET; acc<=0, idx<=WIDTH-1; clears found and err. Probe is held at 0 in IDLE.
  - SET: probe<=acc | (1<<idx); next state EVAL.
  - EVAL: probe is stable for a full cycle, and cmp_* are sampled at the closing edge.
    - eq=1: acc<=probe, found<=1; go to DONE (early exit).
    - eq=0, gt=1: acc<=probe.
    - eq=0, gt=0: acc unchanged.
    - If no early exit: idx==0 goes to DONE; otherwise idx<=idx-1 and go to SET.
  - DONE: done=1, result<=acc, busy=1; next state IDLE.
- Timing: start sampled at edge k. Trial n (1-based) ends at edge k+2n. The DONE cycle follows that edge. Worst case is WIDTH trials, so done follows edge k+2·WIDTH (edge k+8 for WIDTH=4).
- result equals A for every A in 0..2^WIDTH-1. For A=0, found=0; for every other A, the eq probe occurs at A's lowest set bit, so found=1.
- Simultaneous gt=1 and eq=1 in EVAL: set err; eq takes priority.
- start outside IDLE (SET/EVAL/DONE) is ignored and not queued. start held high continuously re-launches a search in the cycle after each DONE.
- rst_n asserted mid-search: immediate return to reset values; no done pulse. The search restarts only after a fresh start.
- cmp_* are ignored outside EVAL.

Decomposition:
- Shared package sar_pkg holds:
  - state encoding constants: IDLE=2'd0, SET=2'd1, EVAL=2'd2, DONE=2'd3
  - default WIDTH constant
- Single module; no sub-module needed.
- The verification bench supplies a behavioural comparator model: gt=(A>probe), eq=(A==probe).

Test Plan:
- Mid-range value: WIDTH=4, A=10, pulse start → probes 8,12,10; eq on trial 3; done after edge k+6; result=10, found=1, err=0.
- Zero: A=0 → probes 8,4,2,1; done after edge k+8; result=0, found=0.
- Maximum: A=15 → probes 8,12,14,15; eq on trial 4; done after edge k+8; result=15, found=1.
- Start while busy: A=5, start pulsed again while in EVAL → ignored; exactly one done pulse; result=5.
- Reset mid-search: A=9, rst_n low during the second EVAL → all outputs 0 immediately; no done. Next start yields result=9.
- Faulty comparator: model forces gt=eq=1 on the first EVAL → err=1, early exit, result=8, found=1. err clears on the next start.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller.
//   state_t        : controller state encoding (IDLE/SET/EVAL/DONE)
//   DEFAULT_WIDTH  : default operand width in bits
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sar_search_controller.sv
// Successive-approximation search engine on the B side of a magnitude
// comparator. Drives a registered probe, reads back A>probe / A==probe and
// binary-searches MSB-first to recover the comparator's A operand.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request a search (sampled only in IDLE)
//   probe          : registered trial value to comparator B input
//   cmp_gt, cmp_eq : comparator flags, sampled only at the end of EVAL
//   busy           : high from the cycle after start acceptance through DONE
//   done           : single-cycle pulse, result valid
//   result, found  : recovered A and exact-match flag, held until next search
//   err            : gt and eq seen together in EVAL, sticky until next start
module sar_search_controller
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int unsigned     IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   acc, acc_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [WIDTH-1:0]   probe_nx, result_nx;
  logic               found_nx, err_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      idx    <= IDX_MAX;
      probe  <= '0;
      result <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      idx    <= idx_nx;
      probe  <= probe_nx;
      result <= result_nx;
      found  <= found_nx;
      err    <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    idx_nx    = idx;
    probe_nx  = probe;
    result_nx = result;
    found_nx  = found;
    err_nx    = err;
    case (state)
      IDLE: begin
        probe_nx = '0;
        if (start) begin
          state_nx = SET;
          acc_nx   = '0;
          idx_nx   = IDX_MAX;
          found_nx = 1'b0;
          err_nx   = 1'b0;
        end
      end
      SET: begin
        probe_nx = acc | (WIDTH'(1) << idx);
        state_nx = EVAL;
      end
      EVAL: begin
        if (cmp_gt && cmp_eq) err_nx = 1'b1;
        if (cmp_eq) begin
          acc_nx   = probe;
          found_nx = 1'b1;
          state_nx = DONE;
        end else begin
          if (cmp_gt) acc_nx = probe;
          if (idx == '0) begin
            state_nx = DONE;
          end else begin
            idx_nx   = idx - IDX_W'(1);
            state_nx = SET;
          end
        end
        // result is captured on entry to DONE so it is already valid
        // while the done pulse is high.
        if (state_nx == DONE) result_nx = acc_nx;
      end
      DONE: begin
        probe_nx = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sar_search_controller.sv
module tb_sar_search_controller;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] probe;
  logic         cmp_gt, cmp_eq;
  logic         busy, done, found, err;
  logic [W-1:0] result;

  logic [W-1:0] a_val;
  logic         fault;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;

  sar_search_controller #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .probe  (probe),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Comparator model; fault forces both flags high.
  always_comb begin
    cmp_gt = fault ? 1'b1 : (a_val > probe);
    cmp_eq = fault ? 1'b1 : (a_val == probe);
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Closed-form search behaviour: trials end at A's lowest set bit.
  function automatic int n_trials(input logic [W-1:0] a, input logic f);
    if (f) return 1;
    for (int b = 0; b < W; b++)
      if (a[b]) return W - b;
    return W;
  endfunction

  // Trial j probe: A's bits above position W-j, plus a one at W-j.
  function automatic logic [W-1:0] trial_probe(input logic [W-1:0] a, input logic f, input int j);
    int b, av, p;
    b  = W - j;
    av = int'(a);
    if (f) return W'(1 << (W - 1));
    p = ((av >> (b + 1)) << (b + 1)) | (1 << b);
    return W'(p);
  endfunction

  // Reference model: t = edges since start acceptance, -1 when idle.
  int           t = -1;
  int           n_exp = 1;
  logic [W-1:0] plan_a;
  logic         plan_fault;
  logic [W-1:0] held_res;
  logic         held_found, held_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t          <= -1;
      held_res   <= '0;
      held_found <= 1'b0;
      held_err   <= 1'b0;
    end else if (t < 0) begin
      if (start) begin
        t          <= 0;
        n_exp      <= n_trials(a_val, fault);
        plan_a     <= a_val;
        plan_fault <= fault;
        held_found <= 1'b0;
        held_err   <= 1'b0;
      end
    end else begin
      if (t + 1 == 2 * n_exp) begin
        held_res   <= plan_fault ? W'(1 << (W - 1)) : plan_a;
        held_found <= plan_fault || (plan_a != '0);
        held_err   <= plan_fault;
      end
      if (t + 1 > 2 * n_exp) t <= -1;
      else t <= t + 1;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", int'(busy), int'(t >= 0));
      chk("done", int'(done), int'(t >= 0 && t == 2 * n_exp));
      if (t < 0)
        chk("idle_probe", int'(probe), 0);
      else if (t % 2 == 1)
        chk("probe", int'(probe), int'(trial_probe(plan_a, plan_fault, (t + 1) / 2)));
      if (t < 0 || t == 2 * n_exp) begin
        chk("result", int'(result), int'(held_res));
        chk("found", int'(found), int'(held_found));
        chk("err", int'(err), int'(held_err));
      end else if (t < 2) begin
        chk("found_clr", int'(found), 0);
        chk("err_clr", int'(err), 0);
      end
      if (done) done_cnt++;
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  // Pulse start and count edges from acceptance to the done cycle.
  task automatic launch(input logic [W-1:0] a, input logic f, input int extra, output int cnt);
    wait_idle();
    a_val = a;
    fault = f;
    start = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (!done && cnt < 100) begin
      start = (cnt == extra);
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
    fault = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"},   int'(busy),   0);
    chk({name, "_done"},   int'(done),   0);
    chk({name, "_probe"},  int'(probe),  0);
    chk({name, "_result"}, int'(result), 0);
    chk({name, "_found"},  int'(found),  0);
    chk({name, "_err"},    int'(err),    0);
  endtask

  initial begin
    int cnt, d0, mode, r, g;
    rst_n = 1'b0;
    start = 1'b0;
    a_val = '0;
    fault = 1'b0;
    #3;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Mid-range value: probes 8,12,10, eq on trial 3.
    launch(4'd10, 1'b0, -1, cnt);
    chk("a10_lat", cnt, 6);
    chk("a10_res", int'(result), 10);
    chk("a10_found", int'(found), 1);
    chk("a10_err", int'(err), 0);

    // Zero: all four trials, no match.
    launch(4'd0, 1'b0, -1, cnt);
    chk("a0_lat", cnt, 8);
    chk("a0_res", int'(result), 0);
    chk("a0_found", int'(found), 0);

    // Maximum: eq on the last trial.
    launch(4'd15, 1'b0, -1, cnt);
    chk("a15_lat", cnt, 8);
    chk("a15_res", int'(result), 15);
    chk("a15_found", int'(found), 1);

    // Start re-pulsed during the first EVAL is ignored.
    wait_idle();
    d0 = done_cnt;
    launch(4'd5, 1'b0, 1, cnt);
    chk("a5_lat", cnt, 8);
    chk("a5_res", int'(result), 5);
    repeat (6) @(negedge clk);
    chk("a5_one_done", done_cnt - d0, 1);

    // Reset during the second EVAL.
    wait_idle();
    a_val = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    launch(4'd9, 1'b0, -1, cnt);
    chk("a9_lat", cnt, 8);
    chk("a9_res", int'(result), 9);

    // Faulty comparator on first EVAL: err, early exit with 8.
    launch(4'd10, 1'b1, -1, cnt);
    chk("flt_lat", cnt, 2);
    chk("flt_res", int'(result), 8);
    chk("flt_found", int'(found), 1);
    chk("flt_err", int'(err), 1);
    launch(4'd3, 1'b0, -1, cnt);
    chk("flt_clr_err", int'(err), 0);
    chk("a3_res", int'(result), 3);

    // Randomized phase, checked by the per-cycle compare process.
    for (int i = 0; i < 60; i++) begin
      mode = int'($urandom_range(0, 4));
      case (mode)
        0: launch(W'($urandom), 1'b0, -1, cnt);
        1: launch(W'($urandom), 1'b0, int'($urandom_range(0, 7)), cnt);
        2: launch(W'($urandom), ($urandom_range(0, 3) == 0), -1, cnt);
        3: begin
          wait_idle();
          a_val = W'($urandom);
          start = 1'b1;
          for (int s = 0; s < 3; s++) begin
            g = 0;
            while (!done && g < 100) begin
              @(negedge clk);
              g++;
            end
            if (!done) chk("held_timeout", 0, 1);
            a_val = W'($urandom);
            if (s == 2) start = 1'b0;
            @(negedge clk);
          end
        end
        default: begin
          wait_idle();
          a_val = W'($urandom);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          r = int'($urandom_range(0, 8));
          repeat (r) @(negedge clk);
          #2 rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
        end
      endcase
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
